// File: rtl/cdma_tx_scheduler.sv
// Round-robin, burst-limited scheduler feeding one bit at a time from two users into cdma_transmitter.
// Latency: handshake in cycle T -> chip 0 in T+1. Backpressure: uN_ready only for the slot winner.
// Optional guard gap on user switch: define CDMA_TX_SCHED_GUARD_EN.
module cdma_tx_scheduler #(
    parameter int CHIPS_PER_BIT = 6,
    parameter int BURST_LEN     = 4,
    parameter int GUARD_CHIPS   = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             u1_valid,
    input  logic                             u1_bit,
    output logic                             u1_ready,
    input  logic                             u2_valid,
    input  logic                             u2_bit,
    output logic                             u2_ready,
    output logic                             tx_valid,
    output logic                             tx_data,
    output logic                             tx_user_sel,
    output logic [$clog2(CHIPS_PER_BIT)-1:0] chip_idx,
    output logic                             bit_start,
    output logic                             busy
);

    localparam int CW = $clog2(CHIPS_PER_BIT);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] LAST_CHIP = CW'(CHIPS_PER_BIT - 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN);

    generate
        if (CHIPS_PER_BIT < 2 || BURST_LEN < 1 || GUARD_CHIPS < 1) begin : g_param_check
            $error("cdma_tx_scheduler: parameter out of range");
        end
    endgenerate

`ifdef CDMA_TX_SCHED_GUARD_EN
    localparam int GW = (GUARD_CHIPS > 1) ? $clog2(GUARD_CHIPS) : 1;
    localparam logic [GW-1:0] LAST_GUARD = GW'(GUARD_CHIPS - 1);
    typedef enum logic [1:0] {IDLE = 2'd0, SPREAD = 2'd1, GUARD = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SPREAD = 2'd1} state_t;
`endif

    state_t        state, state_nxt;
    logic [CW-1:0] chip_q;
    logic [BW-1:0] burst_cnt;
    logic          last_user;   // 0 = user 1, 1 = user 2
    logic          data_q;
    logic          sel_q;

    logic slot_last;
    logic slot_open;
    logic keep_last;
    logic grant;
    logic win_u2;
    logic win_bit;

`ifdef CDMA_TX_SCHED_GUARD_EN
    logic [GW-1:0] guard_cnt;
`endif

    assign slot_last = (state == SPREAD) && (chip_q == LAST_CHIP);
    // Readies are gated by reset so nothing is consumed while the chain is being cleared.
    assign slot_open = rst_n && ((state == IDLE) || slot_last);
    assign keep_last = slot_last && (burst_cnt < BURST_MAX);

    always_comb begin
        win_u2 = 1'b0;
        if (u1_valid && u2_valid) begin
            win_u2 = keep_last ? last_user : ~last_user;
        end else begin
            win_u2 = u2_valid;
        end
    end

    assign grant    = slot_open && (u1_valid || u2_valid);
    assign win_bit  = win_u2 ? u2_bit : u1_bit;
    assign u1_ready = grant && !win_u2;
    assign u2_ready = grant && win_u2;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = SPREAD;
                end
            end
            SPREAD: begin
                if (slot_last) begin
                    if (!grant) begin
                        state_nxt = IDLE;
`ifdef CDMA_TX_SCHED_GUARD_EN
                    end else if (win_u2 != sel_q) begin
                        state_nxt = GUARD;
`endif
                    end else begin
                        state_nxt = SPREAD;
                    end
                end
            end
`ifdef CDMA_TX_SCHED_GUARD_EN
            GUARD: begin
                if (guard_cnt == LAST_GUARD) begin
                    state_nxt = SPREAD;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chip_q    <= '0;
            burst_cnt <= '0;
            last_user <= 1'b1;
            data_q    <= 1'b0;
            sel_q     <= 1'b0;
        end else if (grant) begin
            chip_q    <= '0;
            data_q    <= win_bit;
            sel_q     <= win_u2;
            last_user <= win_u2;
            if (win_u2 == last_user) begin
                if (burst_cnt != BURST_MAX) begin
                    burst_cnt <= burst_cnt + BW'(1);
                end
            end else begin
                burst_cnt <= BW'(1);
            end
        end else if (state == SPREAD) begin
            chip_q <= slot_last ? '0 : chip_q + CW'(1);
        end
    end

`ifdef CDMA_TX_SCHED_GUARD_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            guard_cnt <= '0;
        end else if (state == GUARD) begin
            guard_cnt <= guard_cnt + GW'(1);
        end else begin
            guard_cnt <= '0;
        end
    end
`endif

    assign tx_valid    = (state == SPREAD);
    assign tx_data     = data_q;
    assign tx_user_sel = sel_q;
    assign chip_idx    = chip_q;
    assign bit_start   = tx_valid && (chip_q == '0);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_cdma_tx_scheduler.sv
// Bench for cdma_tx_scheduler: directed user bit streams, expected (user, bit) grants queued by hand,
// a negedge monitor pops and checks each bit plus per-cycle timing rules.
module tb_cdma_tx_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       u1_valid, u1_bit, u1_ready;
    logic       u2_valid, u2_bit, u2_ready;
    logic       tx_valid, tx_data, tx_user_sel, bit_start, busy;
    logic [2:0] chip_idx;

    always #5 clk = ~clk;

    cdma_tx_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .u1_valid    (u1_valid),
        .u1_bit      (u1_bit),
        .u1_ready    (u1_ready),
        .u2_valid    (u2_valid),
        .u2_bit      (u2_bit),
        .u2_ready    (u2_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_user_sel (tx_user_sel),
        .chip_idx    (chip_idx),
        .bit_start   (bit_start),
        .busy        (busy)
    );

`ifdef CDMA_TX_SCHED_GUARD_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 0;
`endif

    typedef struct packed {
        logic usr;
        logic dat;
    } exp_t;

    exp_t  exp_q[$];
    bit    q1[$];
    bit    q2[$];
    string chk_name[$];
    int    chk_act[$];
    int    chk_exp[$];
    int    bs_log[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int txv_cnt = 0;
    int gap_cnt = 0;

    // ---------------- checking (monitor is the only process that counts) ----------------
    function automatic void cmp(string n, int a, int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
        end
    endfunction

    function automatic void expect_eq(string n, int a, int e);
        chk_name.push_back(n);
        chk_act.push_back(a);
        chk_exp.push_back(e);
    endfunction

    function automatic void push_exp(logic u, logic d);
        exp_t e;
        e.usr = u;
        e.dat = d;
        exp_q.push_back(e);
    endfunction

    logic       prev_ok = 1'b0;
    logic       prev_hs = 1'b0;
    logic       prev_hs_u2 = 1'b0;
    logic       prev_txv = 1'b0;
    logic       prev_sel = 1'b0;
    logic       prev_data = 1'b0;
    logic [2:0] prev_chip = '0;

    always @(negedge clk) begin
        logic hs;
        logic hs_u2;
        exp_t e;
        cyc++;
        while (chk_name.size() > 0) begin
            cmp(chk_name.pop_front(), chk_act.pop_front(), chk_exp.pop_front());
        end
        if (!rst_n) begin
            prev_ok = 1'b0;
        end else begin
            hs    = (u1_valid && u1_ready) || (u2_valid && u2_ready);
            hs_u2 = u2_valid && u2_ready;
            if (tx_valid) txv_cnt++;
            if (busy && !tx_valid) begin
                gap_cnt++;
                cmp("guard_ready", int'(u1_ready | u2_ready), 0);
            end
            if (tx_valid && bit_start) begin
                bs_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    cmp("unexpected_bit", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    cmp("bit_user", int'(tx_user_sel), int'(e.usr));
                    cmp("bit_data", int'(tx_data), int'(e.dat));
                end
            end
            if (prev_ok) begin
                if (prev_hs) begin
                    cmp("latched_user", int'(tx_user_sel), int'(prev_hs_u2));
                    if (GAP > 0 && prev_txv && (prev_hs_u2 != prev_sel)) begin
                        cmp("guard_entry", int'({busy, tx_valid}), 2);
                    end else begin
                        cmp("start_vld", int'(tx_valid), 1);
                        cmp("start_pulse", int'(bit_start), 1);
                        cmp("start_chip", int'(chip_idx), 0);
                    end
                end else begin
                    cmp("hold_data", int'(tx_data), int'(prev_data));
                    cmp("hold_sel", int'(tx_user_sel), int'(prev_sel));
                    if (prev_txv && prev_chip == 3'd5) cmp("idle_after_bit", int'(busy), 0);
                end
            end
            prev_ok    = 1'b1;
            prev_hs    = hs;
            prev_hs_u2 = hs_u2;
            prev_txv   = tx_valid;
            prev_sel   = tx_user_sel;
            prev_data  = tx_data;
            prev_chip  = chip_idx;
        end
    end

    // ---------------- stimulus ----------------
    function automatic void drive();
        u1_valid = (q1.size() > 0);
        u1_bit   = (q1.size() > 0) ? q1[0] : 1'b0;
        u2_valid = (q2.size() > 0);
        u2_bit   = (q2.size() > 0) ? q2[0] : 1'b0;
    endfunction

    function automatic void give(int u, logic [15:0] b, int n);
        for (int i = 0; i < n; i++) begin
            if (u == 1) q1.push_back(b[i]);
            else        q2.push_back(b[i]);
        end
    endfunction

    task automatic step();
        bit h1, h2;
        @(negedge clk);
        h1 = u1_valid && u1_ready;
        h2 = u2_valid && u2_ready;
        @(posedge clk);
        #1;
        if (h1) void'(q1.pop_front());
        if (h2) void'(q2.pop_front());
        drive();
    endtask

    task automatic run_until_idle(int max, string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while ((busy || q1.size() > 0 || q2.size() > 0) && n < max);
        if (n >= max) expect_eq({tag, "_timeout"}, 1, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(string tag);
        expect_eq({tag, "_tx_valid"}, int'(tx_valid), 0);
        expect_eq({tag, "_tx_data"}, int'(tx_data), 0);
        expect_eq({tag, "_tx_user_sel"}, int'(tx_user_sel), 0);
        expect_eq({tag, "_chip_idx"}, int'(chip_idx), 0);
        expect_eq({tag, "_bit_start"}, int'(bit_start), 0);
        expect_eq({tag, "_busy"}, int'(busy), 0);
        expect_eq({tag, "_u1_ready"}, int'(u1_ready), 0);
        expect_eq({tag, "_u2_ready"}, int'(u2_ready), 0);
    endtask

    initial begin
        int base_txv, base_gap, base_bs, n;

        // Reset with both users valid: nothing granted, then U1 wins the first tie.
        rst_n = 1'b0;
        give(1, 16'h0001, 1);
        give(2, 16'h0000, 1);
        drive();
        push_exp(1'b0, 1'b1);
        push_exp(1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        #1;
        expect_eq("release_u1_ready", int'(u1_ready), 1);
        expect_eq("release_u2_ready", int'(u2_ready), 0);
        run_until_idle(100, "t0");
        expect_eq("t0_drain", exp_q.size(), 0);

        // Single user, three bits of 1: 18 contiguous chips, bit starts 6 apart.
        do_reset();
        base_txv = txv_cnt;
        base_gap = gap_cnt;
        base_bs  = bs_log.size();
        give(1, 16'h0007, 3);
        drive();
        repeat (3) push_exp(1'b0, 1'b1);
        run_until_idle(100, "t1");
        expect_eq("t1_chips", txv_cnt - base_txv, 18);
        expect_eq("t1_gaps", gap_cnt - base_gap, 0);
        expect_eq("t1_bits", bs_log.size() - base_bs, 3);
        if (bs_log.size() - base_bs == 3) begin
            expect_eq("t1_bit1_offset", bs_log[base_bs + 1] - bs_log[base_bs], 6);
            expect_eq("t1_bit2_offset", bs_log[base_bs + 2] - bs_log[base_bs], 12);
        end
        expect_eq("t1_sel", int'(tx_user_sel), 0);

        // Both users requesting: U1 x4, U2 x4, U1 x4.
        do_reset();
        base_txv = txv_cnt;
        base_gap = gap_cnt;
        base_bs  = bs_log.size();
        give(1, 16'h004D, 8);   // 1,0,1,1,0,0,1,0
        give(2, 16'h0006, 4);   // 0,1,1,0
        drive();
        push_exp(1'b0, 1'b1); push_exp(1'b0, 1'b0); push_exp(1'b0, 1'b1); push_exp(1'b0, 1'b1);
        push_exp(1'b1, 1'b0); push_exp(1'b1, 1'b1); push_exp(1'b1, 1'b1); push_exp(1'b1, 1'b0);
        push_exp(1'b0, 1'b0); push_exp(1'b0, 1'b0); push_exp(1'b0, 1'b1); push_exp(1'b0, 1'b0);
        run_until_idle(300, "t2");
        expect_eq("t2_chips", txv_cnt - base_txv, 72);
        expect_eq("t2_gaps", gap_cnt - base_gap, 2 * GAP);
        expect_eq("t2_bits", bs_log.size() - base_bs, 12);
        if (bs_log.size() - base_bs == 12) begin
            expect_eq("t2_span", bs_log[base_bs + 11] - bs_log[base_bs], 66 + 2 * GAP);
        end

        // Single U2 bit, then idle: outputs hold.
        give(2, 16'h0001, 1);
        drive();
        push_exp(1'b1, 1'b1);
        run_until_idle(100, "t3");
        expect_eq("t3_busy", int'(busy), 0);
        expect_eq("t3_tx_valid", int'(tx_valid), 0);
        step();
        step();
        expect_eq("t3_hold_data", int'(tx_data), 1);
        expect_eq("t3_hold_sel", int'(tx_user_sel), 1);

        // Reset at chip 3 of a U2 bit while another U2 bit waits; U1 then wins the tie.
        do_reset();
        give(2, 16'h0001, 2);   // 1,0
        drive();
        push_exp(1'b1, 1'b1);
        n = 0;
        do begin
            step();
            n++;
        end while (!(tx_valid && chip_idx == 3'd3) && n < 50);
        if (n >= 50) expect_eq("t4_reach_chip3_timeout", 1, 0);
        give(1, 16'h0000, 1);
        drive();
        rst_n = 1'b0;
        step();
        check_all_zero("midbit");
        rst_n = 1'b1;
        #1;
        expect_eq("t4_u1_ready", int'(u1_ready), 1);
        expect_eq("t4_u2_ready", int'(u2_ready), 0);
        push_exp(1'b0, 1'b0);
        push_exp(1'b1, 1'b0);
        run_until_idle(100, "t4");
        expect_eq("final_drain", exp_q.size(), 0);

        repeat (3) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
